// File: rtl/ser_tx_pkg.sv
// rtl/ser_tx_pkg.sv - state encoding and counter sizing shared by the word serializer
package ser_tx_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  // One counter serves both the bit countdown and the idle gap countdown.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fsm_ser_word_tx_shift_reg.sv
// rtl/fsm_ser_word_tx_shift_reg.sv - parallel-load, zero-fill left shift register with MSB tap
module ser_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_val;
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/fsm_ser_word_tx.sv
// rtl/fsm_ser_word_tx.sv - MSB-first word serializer with framing strobes and idle gap
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module fsm_ser_word_tx
  import ser_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH, GAP);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             accept;
  logic             last_bit;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_val;

  assign accept = (state_q == ser_tx_pkg::IDLE) && din_valid;

`ifdef SER_PARITY_EN
  logic par_q, par_d;

  assign last_bit = (state_q == ser_tx_pkg::PAR);
  assign par_d    = accept ? ^din : par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign last_bit = (state_q == ser_tx_pkg::SHIFT) && (cnt_q == '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ser_tx_pkg::IDLE;
      cnt_q         <= '0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (last_bit) begin
      if (GAP > 0) begin
        state_d = ser_tx_pkg::GAP;
        cnt_d   = CW'(GAP - 1);
      end else begin
        state_d = ser_tx_pkg::IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ser_tx_pkg::IDLE: begin
          if (din_valid) begin
            state_d = ser_tx_pkg::SHIFT;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
        ser_tx_pkg::SHIFT: begin
          // Reaching zero here only happens when a parity bit follows.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = ser_tx_pkg::PAR;
          end
        end
        ser_tx_pkg::GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = ser_tx_pkg::IDLE;
          end
        end
        default: begin
          state_d = ser_tx_pkg::IDLE;
        end
      endcase
    end
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    ser_valid_d   = (state_d == ser_tx_pkg::SHIFT) || (state_d == ser_tx_pkg::PAR);
    frame_start_d = accept;
    sh_load       = accept;
    sh_val        = din;
    sh_shift      = (state_q == ser_tx_pkg::SHIFT) || (state_q == ser_tx_pkg::PAR);
`ifdef SER_PARITY_EN
    frame_end_d   = (state_d == ser_tx_pkg::PAR);
    if ((state_q == ser_tx_pkg::SHIFT) && (cnt_q == '0)) begin
      sh_load = 1'b1;
      sh_val  = {par_q, {(WIDTH-1){1'b0}}};
    end
`else
    frame_end_d   = (state_d == ser_tx_pkg::SHIFT) && (cnt_d == '0);
`endif
  end

  // ser_out is the shift register MSB flop; zero fill leaves it low outside a word.
  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_val),
    .msb      (ser_out)
  );

  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign din_ready   = (state_q == ser_tx_pkg::IDLE);
  assign busy        = (state_q != ser_tx_pkg::IDLE);

endmodule

// File: tb/tb_fsm_ser_word_tx.sv
// tb/tb_fsm_ser_word_tx.sv - scoreboard bench for fsm_ser_word_tx (honours SER_PARITY_EN)
module tb_fsm_ser_word_tx;

  localparam int W = 8;
  localparam int G = 2;
`ifdef SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, ser_out, ser_valid, frame_start, frame_end, busy;

  fsm_ser_word_tx #(.WIDTH(W), .GAP(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  exp_t exp_q[$];
  int   fs_hist[$];
  int   edge_n = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  bit   mon_en = 1'b0;
  int   busy_from = 0;
  int   busy_to = 0;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, edge_n);
    end
  endtask

  // Reference: a word accepted at edge E shows bit k (MSB first) during cycle E+k.
  task automatic push_word(input logic [W-1:0] d);
    exp_t x;
    int   e_cyc;
    int   ones;
    e_cyc = edge_n + 1;
    ones  = 0;
    for (int k = 0; k < W; k++) begin
      x.cyc = e_cyc + k;
      x.b   = d[W-1-k];
      x.fs  = (k == 0);
      x.fe  = (k == W - 1) && (P == 0);
      ones += int'(d[W-1-k]);
      exp_q.push_back(x);
    end
    if (P == 1) begin
      x.cyc = e_cyc + W;
      x.b   = 1'((ones % 2));
      x.fs  = 1'b0;
      x.fe  = 1'b1;
      exp_q.push_back(x);
    end
    busy_from = e_cyc;
    busy_to   = e_cyc + W + P + G;
  endtask

  task automatic drive_cycle(input logic v, input logic [W-1:0] d, output bit acc);
    @(negedge clk);
    din_valid = v;
    din       = d;
    acc       = 1'b0;
    if (v && din_ready) begin
      push_word(d);
      acc = 1'b1;
    end
  endtask

  task automatic send_held(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) drive_cycle(1'b1, d, acc);
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic go_idle();
    bit acc;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, din, acc);
      if (exp_q.size() == 0 && din_ready) break;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    #1;
    if (mon_en) begin
      if (ser_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(ser_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("bit_cycle", 32'(edge_n), 32'(e.cyc));
          chk("ser_out", 32'(ser_out), 32'(e.b));
          chk("frame_start", 32'(frame_start), 32'(e.fs));
          chk("frame_end", 32'(frame_end), 32'(e.fe));
        end
      end else begin
        chk("idle_ser_out", 32'(ser_out), 32'd0);
        chk("idle_frame_start", 32'(frame_start), 32'd0);
        chk("idle_frame_end", 32'(frame_end), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
          chk("missing_bit", 32'(ser_valid), 32'd1);
          void'(exp_q.pop_front());
        end
      end
      if (frame_start) fs_hist.push_back(edge_n);
      exp_ready = !(edge_n >= busy_from && edge_n < busy_to);
      chk("din_ready", 32'(din_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!exp_ready));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_din_ready"}, 32'(din_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ser_out"}, 32'(ser_out), 32'd0);
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_frame_end"}, 32'(frame_end), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", edge_n);
    $fatal(1);
  end

  initial begin
    bit acc;
    #1;
    chk_reset_outputs("reset");
    #14;
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Single word with a one-cycle valid.
    drive_cycle(1'b1, 8'hA5, acc);
    chk("a5_accept", 32'(acc), 32'd1);
    go_idle();

    // Back-to-back with valid held continuously.
    fs_hist.delete();
    send_held(8'h99);
    send_held(8'h3C);
    go_idle();
    if (fs_hist.size() >= 2)
      chk("fs_spacing", 32'(fs_hist[1] - fs_hist[0]), 32'(W + G + 1 + P));
    else
      chk("fs_count", 32'(fs_hist.size()), 32'd2);

    // Different words presented while busy must be ignored until IDLE.
    send_held(8'h5A);
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) drive_cycle(1'b1, W'($urandom), acc);
    chk("busy_noise_accept", 32'(acc), 32'd1);
    go_idle();

    // Asynchronous reset in the middle of a word.
    drive_cycle(1'b1, 8'hFF, acc);
    repeat (4) drive_cycle(1'b0, 8'hFF, acc);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midword_reset");
    exp_q.delete();
    busy_from = 0;
    busy_to   = 0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (W + G + 2) drive_cycle(1'b0, 8'h00, acc);

    // Randomized traffic with random valid duty and din changing while busy.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0), W'($urandom), acc);
    end
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
